stream_fifo: RTL and testbench

//  Parametrised synchronous FIFO with valid/ready handshakes on both sides, first-word-fall-through output,

---
 rtl/stream_fifo_pkg.sv | 24 ++
 rtl/stream_fifo_ptr.sv | 25 ++
 rtl/stream_fifo.sv | 115 +++++++++++
 tb/tb_stream_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared sizing helpers and default thresholds for stream_fifo.
// Optional statistics ports are enabled by defining STREAM_FIFO_STATS_EN.
package stream_fifo_pkg;

    localparam int DEF_WORD_WIDTH    = 8;
    localparam int DEF_ADD_WIDTH     = 4;
    localparam int DEF_AFULL_THRESH  = 12;
    localparam int DEF_AEMPTY_THRESH = 4;
    localparam int DROP_CNT_WIDTH    = 16;

    function automatic int fifo_depth(input int add_width);
        return 1 << add_width;
    endfunction

    // One extra wrap bit distinguishes full from empty when the low bits match.
    function automatic int ptr_width(input int add_width);
        return add_width + 1;
    endfunction

    function automatic int level_width(input int add_width);
        return add_width + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_ptr.sv
// Wrapping FIFO pointer with wrap bit; clear has priority over increment.
// Instantiated once for the write side and once for the read side.
module stream_fifo_ptr
    import stream_fifo_pkg::*;
#(
    parameter int PTR_W = ptr_width(DEF_ADD_WIDTH)
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO with first-word-fall-through output, level and threshold flags.
// Define STREAM_FIFO_STATS_EN to add hwm_out and drop_cnt_out statistics ports.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int ADD_WIDTH     = DEF_ADD_WIDTH,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  flush_in,
    input  logic                  vld_in,
    output logic                  rdy_out,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic                  vld_out,
    input  logic                  rdy_in,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic [ADD_WIDTH:0]    level_out,
    output logic                  almost_full_out,
    output logic                  almost_empty_out
`ifdef STREAM_FIFO_STATS_EN
    ,
    output logic [ADD_WIDTH:0]    hwm_out,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_out
`endif
);

    localparam int DEPTH = fifo_depth(ADD_WIDTH);
    localparam int PTR_W = ptr_width(ADD_WIDTH);
    localparam int LVL_W = level_width(ADD_WIDTH);

    localparam logic [LVL_W-1:0] AFULL_LVL  = LVL_W'(AFULL_THRESH);
    localparam logic [LVL_W-1:0] AEMPTY_LVL = LVL_W'(AEMPTY_THRESH);

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [ADD_WIDTH-1:0] wr_addr;
    logic [ADD_WIDTH-1:0] rd_addr;
    logic [LVL_W-1:0]     level;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    assign wr_addr = wr_ptr[ADD_WIDTH-1:0];
    assign rd_addr = rd_ptr[ADD_WIDTH-1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_addr == rd_addr) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign level = wr_ptr - rd_ptr;

    // Readiness comes only from registered pointers, so a full FIFO refuses a push even while popping.
    assign rdy_out = ~full;
    assign vld_out = ~empty;
    assign push    = vld_in & rdy_out;
    assign pop     = vld_out & rdy_in;

    stream_fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clr      (flush_in),
        .inc      (push),
        .ptr      (wr_ptr)
    );

    stream_fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clr      (flush_in),
        .inc      (pop),
        .ptr      (rd_ptr)
    );

    always_ff @(posedge clk_in) begin
        if (push && !flush_in) begin
            mem[wr_addr] <= data_in;
        end
    end

    assign data_out         = empty ? '0 : mem[rd_addr];
    assign level_out        = level;
    assign almost_full_out  = (level >= AFULL_LVL);
    assign almost_empty_out = (level <= AEMPTY_LVL);

`ifdef STREAM_FIFO_STATS_EN
    logic [LVL_W-1:0]          hwm;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            hwm      <= '0;
            drop_cnt <= '0;
        end else if (flush_in) begin
            hwm      <= '0;
            drop_cnt <= '0;
        end else begin
            if (level > hwm) begin
                hwm <= level;
            end
            // Saturating count of cycles where the producer was stalled by a full FIFO.
            if (vld_in && !rdy_out && (drop_cnt != {DROP_CNT_WIDTH{1'b1}})) begin
                drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
            end
        end
    end

    assign hwm_out      = hwm;
    assign drop_cnt_out = drop_cnt;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed-vector bench for stream_fifo with hand-computed expectations.
// Statistics checks are compiled in when STREAM_FIFO_STATS_EN is defined.
module tb_stream_fifo;

    logic       clk_in;
    logic       reset_in;
    logic       flush_in;
    logic       vld_in;
    logic       rdy_out;
    logic [7:0] data_in;
    logic       vld_out;
    logic       rdy_in;
    logic [7:0] data_out;
    logic [4:0] level_out;
    logic       almost_full_out;
    logic       almost_empty_out;
`ifdef STREAM_FIFO_STATS_EN
    logic [4:0]  hwm_out;
    logic [15:0] drop_cnt_out;
`endif

    int nvec = 0;
    int nerr = 0;

    stream_fifo dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .flush_in         (flush_in),
        .vld_in           (vld_in),
        .rdy_out          (rdy_out),
        .data_in          (data_in),
        .vld_out          (vld_out),
        .rdy_in           (rdy_in),
        .data_out         (data_out),
        .level_out        (level_out),
        .almost_full_out  (almost_full_out),
        .almost_empty_out (almost_empty_out)
`ifdef STREAM_FIFO_STATS_EN
        ,
        .hwm_out          (hwm_out),
        .drop_cnt_out     (drop_cnt_out)
`endif
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        if (obs !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vld"},   32'(vld_out), 32'd0);
        chk({tag, "_rdy"},   32'(rdy_out), 32'd1);
        chk({tag, "_level"}, 32'(level_out), 32'd0);
        chk({tag, "_data"},  32'(data_out), 32'd0);
    endtask

    initial begin
        reset_in = 1'b1;
        flush_in = 1'b0;
        vld_in   = 1'b0;
        rdy_in   = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        #1;
        chk_idle("rst");
        chk("rst_ae", 32'(almost_empty_out), 32'd1);
        chk("rst_af", 32'(almost_full_out), 32'd0);

        // Latency: push in cycle N, visible at N+1
        vld_in  = 1'b1;
        data_in = 8'hA5;
        chk("lat_pre_vld", 32'(vld_out), 32'd0);
        step();
        vld_in = 1'b0;
        chk("lat_vld",   32'(vld_out), 32'd1);
        chk("lat_data",  32'(data_out), 32'hA5);
        chk("lat_level", 32'(level_out), 32'd1);
        rdy_in = 1'b1;
        step();
        rdy_in = 1'b0;
        chk_idle("lat_pop");

        // Fill to 16 with consumer stalled
        for (int i = 1; i <= 16; i++) begin
            vld_in  = 1'b1;
            data_in = 8'(i);
            step();
            chk("fill_level", 32'(level_out), 32'(i));
            chk("fill_af",    32'(almost_full_out), 32'(i >= 12));
            chk("fill_ae",    32'(almost_empty_out), 32'(i <= 4));
        end
        chk("fill_rdy", 32'(rdy_out), 32'd0);
        data_in = 8'h11;
        step();
        vld_in = 1'b0;
        chk("fill_17_level", 32'(level_out), 32'd16);
        chk("fill_17_head",  32'(data_out), 32'h01);
`ifdef STREAM_FIFO_STATS_EN
        chk("fill_drop", 32'(drop_cnt_out), 32'd1);
        chk("fill_hwm",  32'(hwm_out), 32'd16);
`endif

        // Drain in order
        rdy_in = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_vld",  32'(vld_out), 32'd1);
            chk("drain_data", 32'(data_out), 32'(i));
            step();
            chk("drain_level", 32'(level_out), 32'(16 - i));
            chk("drain_ae",    32'(almost_empty_out), 32'((16 - i) <= 4));
        end
        rdy_in = 1'b0;
        chk("drain_end_vld",  32'(vld_out), 32'd0);
        chk("drain_end_data", 32'(data_out), 32'd0);

        // Concurrent push/pop at level 5
        for (int i = 0; i < 5; i++) begin
            vld_in  = 1'b1;
            data_in = 8'(32'h20 + i);
            step();
        end
        chk("conc_level0", 32'(level_out), 32'd5);
        rdy_in = 1'b1;
        for (int k = 0; k < 100; k++) begin
            data_in = 8'(32'h25 + k);
            chk("conc_data", 32'(data_out), 32'(8'(32'h20 + k)));
            step();
            chk("conc_level", 32'(level_out), 32'd5);
        end
        rdy_in = 1'b0;
        for (int i = 0; i < 11; i++) begin
            data_in = 8'(32'h89 + i);
            step();
        end
        chk("conc_full_level", 32'(level_out), 32'd16);
        chk("conc_full_head",  32'(data_out), 32'h84);
        rdy_in  = 1'b1;
        data_in = 8'hEE;
        chk("conc_full_rdy", 32'(rdy_out), 32'd0);
        step();
        vld_in = 1'b0;
        rdy_in = 1'b0;
        chk("fullpop_level", 32'(level_out), 32'd15);
        chk("fullpop_head",  32'(data_out), 32'h85);

        // Flush
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        chk("flush1_level", 32'(level_out), 32'd0);
        for (int i = 0; i < 9; i++) begin
            vld_in  = 1'b1;
            data_in = 8'(32'h30 + i);
            step();
        end
        chk("flush_pre_level", 32'(level_out), 32'd9);
        flush_in = 1'b1;
        data_in  = 8'h77;
        step();
        chk_idle("flush");
`ifdef STREAM_FIFO_STATS_EN
        chk("flush_hwm",  32'(hwm_out), 32'd0);
        chk("flush_drop", 32'(drop_cnt_out), 32'd0);
`endif
        flush_in = 1'b0;
        vld_in   = 1'b0;
        step();
        chk("flush_after_level", 32'(level_out), 32'd0);
        vld_in  = 1'b1;
        data_in = 8'h5A;
        step();
        vld_in = 1'b0;
        chk("flush_repush_data",  32'(data_out), 32'h5A);
        chk("flush_repush_level", 32'(level_out), 32'd1);

        // Asynchronous reset mid-traffic
        vld_in  = 1'b1;
        data_in = 8'h66;
        step();
        chk("pre_rst_level", 32'(level_out), 32'd2);
        reset_in = 1'b1;
        #1;
        chk_idle("async_rst");
        chk("async_rst_ae", 32'(almost_empty_out), 32'd1);
        step();
        reset_in = 1'b0;
        vld_in   = 1'b0;
        step();
        chk_idle("post_rst");
`ifdef STREAM_FIFO_STATS_EN
        chk("post_rst_hwm", 32'(hwm_out), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
